// File: rtl/reed_conditioner_if.sv
// Signal bundle between the reed switch front end and its consumers.
// The master side is the conditioner: it takes the raw contact and drives the conditioned outputs.
interface reed_conditioner_if;
  logic        reed_raw;
  logic        reed;
  logic        reed_level;
  logic        stopped;
  logic [15:0] period;

  modport master (input reed_raw, output reed, reed_level, stopped, period);
  modport slave  (output reed_raw, input reed, reed_level, stopped, period);
endinterface

// File: rtl/reed_conditioner.sv
// Reed switch front end: synchronise, debounce, one strobe per revolution,
// revolution period measurement and standstill detection.
module reed_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 50000
) (
  input  logic              clock,
  input  logic              reset,
  reed_conditioner_if.master bus
);

  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {OPEN, CLOSING, CLOSED, OPENING} state_t;

  state_t      state, state_next;
  logic        s1, s2;
  logic [7:0]  db, db_next;
  logic        strobe;
  logic        level_next;
  logic        reed_q, level_q, stopped_q;
  logic [15:0] gap, gap_inc, period_q;

  assign bus.reed       = reed_q;
  assign bus.reed_level = level_q;
  assign bus.stopped    = stopped_q;
  assign bus.period     = period_q;
  assign gap_inc        = gap + 16'd1;

  // Two-flop synchroniser for the asynchronous contact
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.reed_raw;
      s2 <= s1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= OPEN;
      db      <= 8'd0;
      reed_q  <= 1'b0;
      level_q <= 1'b0;
    end else begin
      state   <= state_next;
      db      <= db_next;
      reed_q  <= strobe;
      level_q <= level_next;
    end
  end

  always_comb begin
    state_next = state;
    db_next    = db;
    strobe     = 1'b0;
    case (state)
      OPEN: begin
        if (s2) begin
          state_next = CLOSING;
          db_next    = 8'd0;
        end
      end
      CLOSING: begin
        if (!s2) begin
          state_next = OPEN;
        end else if (db == DB_LAST) begin
          state_next = CLOSED;
          strobe     = 1'b1;
        end else begin
          db_next = db + 8'd1;
        end
      end
      CLOSED: begin
        if (!s2) begin
          state_next = OPENING;
          db_next    = 8'd0;
        end
      end
      OPENING: begin
        // A bounce back to closed during release is the same closure: no strobe
        if (s2) begin
          state_next = CLOSED;
        end else if (db == DB_LAST) begin
          state_next = OPEN;
        end else begin
          db_next = db + 8'd1;
        end
      end
      default: state_next = OPEN;
    endcase
    level_next = (state_next == CLOSED) || (state_next == OPENING);
  end

  // Gap timer, period capture and standstill flag; a strobe beats a timeout on the same edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gap       <= 16'd0;
      stopped_q <= 1'b1;
      period_q  <= 16'd0;
    end else if (strobe) begin
      gap <= 16'd0;
      if (stopped_q) begin
        stopped_q <= 1'b0;
      end else begin
        period_q <= gap_inc;
      end
    end else if (!stopped_q) begin
      gap <= gap_inc;
      if (gap_inc == TIMEOUT) begin
        stopped_q <= 1'b1;
        period_q  <= 16'd0;
      end
    end
  end

endmodule

// File: doc/reed_conditioner.md
# reed_conditioner

Front end for the wheel reed switch: synchronises the raw, bouncy contact input, debounces it, and emits exactly one single-cycle `reed` strobe per wheel revolution. It is the producer of the `reed` strobe that the distance accumulator consumes. It also measures the revolution period in clock cycles and flags a stopped wheel for the speed/display logic.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronised samples required to accept a level change. Legal range is 1..255.
- `TIMEOUT_CYCLES`, default 50000: cycles without an accepted closure before `stopped` asserts. Legal range is 2..65535.
- `clock`  in  1  single system clock; all state updates on its rising edge.
- `reset`  in  1  reset is asynchronous and active-low.
- `reed_raw`  in  1  raw reed contact, asynchronous to `clock`, high = closed.
- `reed`  out  1  one-cycle strobe per accepted closure.
- `reed_level`  out  1  debounced contact level.
- `stopped`  out  1  high while no closure has been accepted within `TIMEOUT_CYCLES`.
- `period`  out  16  cycles between the last two accepted closures; 0 = unknown.

## Operation
- Synchroniser: two flops, `reed_raw` → `s1` → `s2`. The FSM samples only `s2`.
- FSM has four states: OPEN, CLOSING, CLOSED, OPENING. It uses an 8-bit debounce counter `db`.
  - OPEN: if `s2`=1, go to CLOSING and set `db`=0.
  - CLOSING: if `s2`=0, return to OPEN. Else if `db`=DEBOUNCE_CYCLES-1, go to CLOSED and register `reed`=1. Else increment `db`.
  - CLOSED: if `s2`=0, go to OPENING and set `db`=0.
  - OPENING: if `s2`=1, return to CLOSED with no strobe. Else if `db`=DEBOUNCE_CYCLES-1, go to OPEN. Else increment `db`.
- `reed` is registered and is high only on the cycle following a CLOSING→CLOSED transition. It is never high two consecutive cycles.
- `reed_level` = 1 in CLOSED or OPENING, otherwise 0. It is registered with the state.
- Gap counter `gap` is 16 bits.
  - On a strobe edge (the edge that sets `reed`=1), `gap` is cleared to 0.
  - Otherwise, while `stopped`=0, `gap` increments by 1.
  - It holds while `stopped`=1.
- Period capture on a strobe edge:
  - If `stopped`=0, `period` ← `gap`+1, i.e. the edge count since the previous strobe edge.
  - If `stopped`=1, `period` is unchanged and `stopped` ← 0, because the first revolution after standstill has an unknown gap.
- Timeout: on a non-strobe edge where `gap`+1 = TIMEOUT_CYCLES, `stopped` ← 1 and `period` ← 0.
- Simultaneous strobe and timeout on the same edge: the strobe wins. `stopped` stays 0 and `period` ← TIMEOUT_CYCLES.
- Because `gap` never exceeds TIMEOUT_CYCLES-1 while running, `period` needs no saturation logic.

## Timing
- Reset values (asserted asynchronously): `s1`=`s2`=0, state OPEN, `db`=0, `gap`=0, `reed`=0, `reed_level`=0, `stopped`=1, `period`=0.
- Closure latency: let e0 be the first edge sampling `reed_raw`=1, with the input stable from then on. `reed` is high in the cycle after edge e0+DEBOUNCE_CYCLES+2. `reed_level` rises on the same edge.
- Release latency: `reed_level` falls DEBOUNCE_CYCLES+2 edges after the first edge sampling `reed_raw`=0. No strobe is produced on release.
- Rejected glitches:
  - A high pulse on `s2` shorter than DEBOUNCE_CYCLES cycles produces no strobe and leaves `reed_level` unchanged.
  - A low glitch shorter than DEBOUNCE_CYCLES while CLOSED produces no second strobe.
- Running wheel: `stopped` asserts exactly TIMEOUT_CYCLES edges after the last strobe edge.
- Reset asserted mid-debounce or mid-gap: all state clears immediately. No strobe is emitted after release until a full debounce completes.
- After reset release with `reed_raw` held high: a strobe occurs DEBOUNCE_CYCLES+2 edges later, since the contact is treated as a new closure.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=50.
- Clean closure: `reed_raw` rises before edge 0 and stays high. Required: `reed`=1 for exactly one cycle after edge 6, `reed_level`=1 from edge 6, `stopped` 1→0 at edge 6, `period` remains 0.
- Bounce: `reed_raw` toggles 1,0,1,0 each cycle, then is held high. Required: exactly one strobe, 6 edges after the first sample of the final stable high. A 3-cycle high glitch produces no strobe.
- Periodic wheel: clean closures whose strobe edges are 20 edges apart, three revolutions. Required: `period` stays 0 after the first strobe, then reads 20 after the second and third strobes.
- Timeout: stop after one strobe at edge p. Required: `stopped`=1 and `period`=0 at edge p+50 and after. The next strobe clears `stopped` and leaves `period`=0. A strobe exactly 50 edges after the previous one gives `period`=50 and `stopped`=0.
- Reset mid-operation: assert `reset` low while in CLOSING with `db`=2. Required: outputs go to reset values immediately, no strobe afterwards while `reed_raw` is low, and with `reed_raw` held high a strobe appears 6 edges after the release edge.
